// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, registers the fetched word toward decode,
// applies branch/jump redirects and halts on misaligned or out-of-range fetches.
module pc_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_WORDS = 256
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] ImemAddress,
    input  logic [31:0] ImemInstruction,
    input  logic        RedirectValid,
    input  logic [31:0] RedirectTarget,
    input  logic        Stall,
    output logic        InstrValid,
    output logic [31:0] InstrOut,
    output logic [31:0] InstrPC,
    output logic [31:0] InstrPCPlus4,
    output logic        Fault,
    output logic [1:0]  FaultCause,
    output logic [31:0] FetchCount
);

    typedef enum logic {
        RUN  = 1'b0,
        HALT = 1'b1
    } state_t;

    localparam logic [31:0] NOP         = 32'h0000_0013;
    localparam logic [1:0]  CAUSE_NONE  = 2'b00;
    localparam logic [1:0]  CAUSE_ALIGN = 2'b01;
    localparam logic [1:0]  CAUSE_RANGE = 2'b10;
    // Widened so IMEM_WORDS*4 == 2^32 does not overflow the compare.
    localparam logic [32:0] LIMIT = 33'(IMEM_WORDS) * 33'd4;

    state_t      state, state_n;
    logic [31:0] pc, pc_n;
    logic        instr_valid, instr_valid_n;
    logic [31:0] instr_out, instr_out_n;
    logic [31:0] instr_pc, instr_pc_n;
    logic [31:0] instr_pc4, instr_pc4_n;
    logic        fault, fault_n;
    logic [1:0]  cause, cause_n;
    logic [31:0] fetch_count, fetch_count_n;

    logic        load;
    logic        in_range;
    logic [31:0] pc_plus4;

    assign pc_plus4 = pc + 32'd4;
    assign in_range = {1'b0, pc} < LIMIT;
    assign load     = (state == RUN) && (!instr_valid || !Stall);

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            pc          <= RESET_PC;
            instr_valid <= 1'b0;
            instr_out   <= NOP;
            instr_pc    <= 32'd0;
            instr_pc4   <= 32'd0;
            fault       <= 1'b0;
            cause       <= CAUSE_NONE;
            fetch_count <= 32'd0;
        end else begin
            state       <= state_n;
            pc          <= pc_n;
            instr_valid <= instr_valid_n;
            instr_out   <= instr_out_n;
            instr_pc    <= instr_pc_n;
            instr_pc4   <= instr_pc4_n;
            fault       <= fault_n;
            cause       <= cause_n;
            fetch_count <= fetch_count_n;
        end
    end

    always_comb begin
        state_n       = state;
        pc_n          = pc;
        instr_valid_n = instr_valid;
        instr_out_n   = instr_out;
        instr_pc_n    = instr_pc;
        instr_pc4_n   = instr_pc4;
        fault_n       = fault;
        cause_n       = cause;
        fetch_count_n = fetch_count;

        // A handshake completes even when a redirect flushes this cycle.
        if (instr_valid && !Stall) begin
            fetch_count_n = fetch_count + 32'd1;
        end

        unique case (state)
            RUN: begin
                if (RedirectValid) begin
                    instr_valid_n = 1'b0;
                    if (RedirectTarget[1:0] != 2'b00) begin
                        fault_n = 1'b1;
                        cause_n = CAUSE_ALIGN;
                        state_n = HALT;
                    end else begin
                        pc_n = RedirectTarget;
                    end
                end else if (load) begin
                    if (!in_range) begin
                        instr_valid_n = 1'b0;
                        fault_n       = 1'b1;
                        cause_n       = CAUSE_RANGE;
                        state_n       = HALT;
                    end else begin
                        instr_valid_n = 1'b1;
                        instr_out_n   = ImemInstruction;
                        instr_pc_n    = pc;
                        instr_pc4_n   = pc_plus4;
                        pc_n          = pc_plus4;
                    end
                end
            end
            HALT: begin
                instr_valid_n = 1'b0;
            end
            default: begin
                state_n = HALT;
            end
        endcase
    end

    assign ImemAddress  = pc;
    assign InstrValid   = instr_valid;
    assign InstrOut     = instr_out;
    assign InstrPC      = instr_pc;
    assign InstrPCPlus4 = instr_pc4;
    assign Fault        = fault;
    assign FaultCause   = cause;
    assign FetchCount   = fetch_count;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Directed bench for pc_fetch_unit: fetch stream, stall, redirect, faults,
// reset recovery and FetchCount wrap.
module tb_pc_fetch_unit;

    logic        clk;
    logic        rst;
    logic [31:0] ImemAddress;
    logic [31:0] ImemInstruction;
    logic        RedirectValid;
    logic [31:0] RedirectTarget;
    logic        Stall;
    logic        InstrValid;
    logic [31:0] InstrOut;
    logic [31:0] InstrPC;
    logic [31:0] InstrPCPlus4;
    logic        Fault;
    logic [1:0]  FaultCause;
    logic [31:0] FetchCount;

    logic [31:0] imem [256];

    int errors = 0;
    int checks = 0;

    pc_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_WORDS(256)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .ImemAddress    (ImemAddress),
        .ImemInstruction(ImemInstruction),
        .RedirectValid  (RedirectValid),
        .RedirectTarget (RedirectTarget),
        .Stall          (Stall),
        .InstrValid     (InstrValid),
        .InstrOut       (InstrOut),
        .InstrPC        (InstrPC),
        .InstrPCPlus4   (InstrPCPlus4),
        .Fault          (Fault),
        .FaultCause     (FaultCause),
        .FetchCount     (FetchCount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign ImemInstruction = (ImemAddress < 32'h400) ?
        imem[ImemAddress[9:2]] : 32'hDEAD_BEEF;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        imem[0] = 32'h0050_0093;
        imem[1] = 32'h0010_8113;
        for (int i = 2; i < 256; i++) imem[i] = 32'hA000_0000 | 32'(i);

        rst = 1'b1;
        RedirectValid = 1'b0;
        RedirectTarget = 32'd0;
        Stall = 1'b0;

        step();
        chk("rst_addr", ImemAddress, 32'h0);
        chk("rst_valid", 32'(InstrValid), 32'h0);
        chk("rst_out", InstrOut, 32'h0000_0013);
        chk("rst_pc", InstrPC, 32'h0);
        chk("rst_pc4", InstrPCPlus4, 32'h0);
        chk("rst_fault", 32'(Fault), 32'h0);
        chk("rst_cause", 32'(FaultCause), 32'h0);
        chk("rst_cnt", FetchCount, 32'h0);

        // Straight-line fetch
        rst = 1'b0;
        step();
        chk("e1_valid", 32'(InstrValid), 32'h1);
        chk("e1_pc", InstrPC, 32'h0);
        chk("e1_out", InstrOut, 32'h0050_0093);
        chk("e1_pc4", InstrPCPlus4, 32'h4);
        chk("e1_cnt", FetchCount, 32'h0);
        step();
        chk("e2_pc", InstrPC, 32'h4);
        chk("e2_out", InstrOut, 32'h0010_8113);
        chk("e2_pc4", InstrPCPlus4, 32'h8);
        chk("e2_cnt", FetchCount, 32'h1);
        step();
        chk("e3_pc", InstrPC, 32'h8);
        chk("e3_out", InstrOut, 32'hA000_0002);
        chk("e3_pc4", InstrPCPlus4, 32'hC);
        chk("e3_cnt", FetchCount, 32'h2);
        chk("e3_addr", ImemAddress, 32'hC);

        // Stall for three cycles
        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stl_pc", InstrPC, 32'h8);
            chk("stl_out", InstrOut, 32'hA000_0002);
            chk("stl_addr", ImemAddress, 32'hC);
            chk("stl_valid", 32'(InstrValid), 32'h1);
            chk("stl_cnt", FetchCount, 32'h2);
        end
        Stall = 1'b0;
        step();
        chk("rel_pc", InstrPC, 32'hC);
        chk("rel_cnt", FetchCount, 32'h3);

        // Redirect during a stall flushes without counting
        Stall = 1'b1;
        RedirectValid = 1'b1;
        RedirectTarget = 32'h40;
        step();
        chk("rd_valid", 32'(InstrValid), 32'h0);
        chk("rd_addr", ImemAddress, 32'h40);
        chk("rd_cnt", FetchCount, 32'h3);
        Stall = 1'b0;
        RedirectValid = 1'b0;
        step();
        chk("rd1_valid", 32'(InstrValid), 32'h1);
        chk("rd1_pc", InstrPC, 32'h40);
        chk("rd1_out", InstrOut, 32'hA000_0010);
        chk("rd1_cnt", FetchCount, 32'h3);
        step();
        chk("rd2_pc", InstrPC, 32'h44);
        chk("rd2_cnt", FetchCount, 32'h4);

        // Unstalled redirect still counts the consumed instruction
        RedirectValid = 1'b1;
        RedirectTarget = 32'h3F8;
        step();
        chk("rdc_valid", 32'(InstrValid), 32'h0);
        chk("rdc_addr", ImemAddress, 32'h3F8);
        chk("rdc_cnt", FetchCount, 32'h5);
        RedirectValid = 1'b0;
        step();
        chk("end0_pc", InstrPC, 32'h3F8);
        chk("end0_out", InstrOut, 32'hA000_00FE);
        step();
        chk("end1_pc", InstrPC, 32'h3FC);
        chk("end1_out", InstrOut, 32'hA000_00FF);
        chk("end1_pc4", InstrPCPlus4, 32'h400);
        chk("end1_valid", 32'(InstrValid), 32'h1);
        chk("end1_addr", ImemAddress, 32'h400);
        chk("end1_cnt", FetchCount, 32'h6);
        step();
        chk("rng_fault", 32'(Fault), 32'h1);
        chk("rng_cause", 32'(FaultCause), 32'h2);
        chk("rng_valid", 32'(InstrValid), 32'h0);
        chk("rng_addr", ImemAddress, 32'h400);
        chk("rng_cnt", FetchCount, 32'h7);

        // HALT ignores redirects
        RedirectValid = 1'b1;
        RedirectTarget = 32'h0;
        step();
        chk("hlt_addr", ImemAddress, 32'h400);
        chk("hlt_fault", 32'(Fault), 32'h1);
        chk("hlt_valid", 32'(InstrValid), 32'h0);
        RedirectValid = 1'b0;

        rst = 1'b1;
        step();
        chk("rst2_fault", 32'(Fault), 32'h0);
        chk("rst2_cause", 32'(FaultCause), 32'h0);
        chk("rst2_addr", ImemAddress, 32'h0);
        chk("rst2_cnt", FetchCount, 32'h0);
        chk("rst2_out", InstrOut, 32'h0000_0013);

        // Misaligned redirect
        rst = 1'b0;
        step();
        chk("ma0_pc", InstrPC, 32'h0);
        RedirectValid = 1'b1;
        RedirectTarget = 32'h42;
        step();
        chk("ma_fault", 32'(Fault), 32'h1);
        chk("ma_cause", 32'(FaultCause), 32'h1);
        chk("ma_valid", 32'(InstrValid), 32'h0);
        chk("ma_addr", ImemAddress, 32'h4);
        chk("ma_cnt", FetchCount, 32'h1);
        RedirectTarget = 32'h80;
        step();
        chk("ma_ign_addr", ImemAddress, 32'h4);
        chk("ma_ign_cause", 32'(FaultCause), 32'h1);
        RedirectValid = 1'b0;

        rst = 1'b1;
        step();
        chk("rst3_fault", 32'(Fault), 32'h0);

        // Aligned out-of-range target is accepted, faults on the next load
        rst = 1'b0;
        RedirectValid = 1'b1;
        RedirectTarget = 32'h1000;
        step();
        chk("oor_addr", ImemAddress, 32'h1000);
        chk("oor_fault0", 32'(Fault), 32'h0);
        RedirectValid = 1'b0;
        step();
        chk("oor_fault", 32'(Fault), 32'h1);
        chk("oor_cause", 32'(FaultCause), 32'h2);
        chk("oor_valid", 32'(InstrValid), 32'h0);

        // FetchCount wrap
        rst = 1'b1;
        step();
        rst = 1'b0;
        step();
        chk("wr_valid", 32'(InstrValid), 32'h1);
        Stall = 1'b1;
        force dut.fetch_count = 32'hFFFF_FFFF;
        #1;
        release dut.fetch_count;
        step();
        chk("wr_pre", FetchCount, 32'hFFFF_FFFF);
        Stall = 1'b0;
        step();
        chk("wr_post", FetchCount, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
